register_bank_sb: RTL and testbench

Parametrised successor to the pipeline register bank. It has N general registers and a dedicated PC slot, two read ports, and one write port. It adds a per-register busy scoreboard for hazard detection and a masked burst-read sequencer that serves LM/SM-style multi-register transfers one register per handshake. It sits in the decode/register-read stage of the 6-stage pipeline and is written from writeback.

---
 rtl/regbank_pkg.sv | 14 +
 rtl/register_bank_sb_lowest_set_idx.sv | 21 ++
 rtl/register_bank_sb.sv | 197 +++++++++++++++++++
 tb/tb_register_bank_sb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared defaults and burst sequencer state type for register_bank_sb.
package regbank_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } burst_state_t;

endpackage

// File: rtl/register_bank_sb_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of mask, plus a found flag.
module lowest_set_idx #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  assign found = |mask;

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      idx = mask[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/register_bank_sb.sv
// Register bank with PC slot, busy scoreboard and masked burst-read sequencer.
// Optional write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module register_bank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int PC_IDX   = NUM_REGS - 1,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            rd_addr1,
  input  logic [ADDR_W-1:0]            rd_addr2,
  output logic [DATA_W-1:0]            rd_data1,
  output logic [DATA_W-1:0]            rd_data2,
  output logic                         rd_busy1,
  output logic                         rd_busy2,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         pc_wr_en,
  input  logic [DATA_W-1:0]            pc_wr_data,
  output logic [DATA_W-1:0]            pc_out,
  input  logic                         claim_en,
  input  logic [ADDR_W-1:0]            claim_addr,
  output logic [NUM_REGS*DATA_W-1:0]   all_regs,
  input  logic                         burst_start,
  input  logic [NUM_REGS-1:0]          burst_mask,
  input  logic                         burst_ready,
  output logic                         burst_valid,
  output logic [ADDR_W-1:0]            burst_addr,
  output logic [DATA_W-1:0]            burst_data,
  output logic                         burst_busy,
  output logic                         burst_done
);

  localparam logic [ADDR_W-1:0]   PC_A   = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0]   PC_RST = DATA_W'(RESET_PC);
  localparam logic [NUM_REGS-1:0] BIT0   = NUM_REGS'(1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_next, clr_vec, set_vec;
  logic                gen_wr;

  burst_state_t        state, state_next;
  logic [NUM_REGS-1:0] pending, pending_next, cleared, enc_in;
  logic [ADDR_W-1:0]   addr_next, enc_idx;
  logic                enc_found;

  assign gen_wr = wr_en && (wr_addr != PC_A);

  // Register file storage; the general port can never reach the PC slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == PC_IDX) ? PC_RST : '0;
      end
    end else begin
      if (gen_wr) begin
        regs[wr_addr] <= wr_data;
      end
      if (pc_wr_en) begin
        regs[PC_IDX] <= pc_wr_data;
      end
    end
  end

  // Set is applied after clear so a same-cycle claim (newer producer) wins.
  assign clr_vec   = gen_wr ? (BIT0 << wr_addr) : '0;
  assign set_vec   = (claim_en && (claim_addr != PC_A)) ? (BIT0 << claim_addr) : '0;
  assign busy_next = (busy & ~clr_vec) | set_vec;

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign pc_out = regs[PC_IDX];

  // Flat dump of every register, R[0] in the low bits.
  always_comb begin
    all_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      all_regs[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  // Zero-latency read ports, optionally forwarding the in-flight writes.
  always_comb begin
    rd_data1   = regs[rd_addr1];
    rd_data2   = regs[rd_addr2];
    rd_busy1   = busy[rd_addr1];
    rd_busy2   = busy[rd_addr2];
    burst_data = regs[burst_addr];
`ifdef REGBANK_BYPASS_EN
    if (gen_wr && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end else if (pc_wr_en && (rd_addr1 == PC_A)) begin
      rd_data1 = pc_wr_data;
    end else begin
      rd_data1 = regs[rd_addr1];
    end
    if (gen_wr && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      rd_busy2 = 1'b0;
    end else if (pc_wr_en && (rd_addr2 == PC_A)) begin
      rd_data2 = pc_wr_data;
    end else begin
      rd_data2 = regs[rd_addr2];
    end
    if (gen_wr && (wr_addr == burst_addr)) begin
      burst_data = wr_data;
    end else if (pc_wr_en && (burst_addr == PC_A)) begin
      burst_data = pc_wr_data;
    end else begin
      burst_data = regs[burst_addr];
    end
`endif
  end

  assign cleared = pending & ~(BIT0 << burst_addr);

  lowest_set_idx #(.W(NUM_REGS), .IDX_W(ADDR_W)) u_lsb (
    .mask  (enc_in),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Burst sequencer next-state: the encoder looks at the mask that will remain.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    addr_next    = burst_addr;
    enc_in       = '0;
    case (state)
      IDLE: begin
        enc_in = burst_mask;
        if (burst_start) begin
          pending_next = burst_mask;
          if (enc_found) begin
            state_next = EMIT;
            addr_next  = enc_idx;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        enc_in = cleared;
        if (burst_ready) begin
          pending_next = cleared;
          if (enc_found) begin
            addr_next = enc_idx;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = EMIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  // Burst sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      burst_addr <= '0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      burst_addr <= addr_next;
    end
  end

  assign burst_valid = (state == EMIT);
  assign burst_done  = (state == DONE);
  assign burst_busy  = (state != IDLE);

endmodule

// File: tb/tb_register_bank_sb.sv
// Self-checking bench for register_bank_sb: directed scenarios plus random
// traffic compared against a queue/array reference model.
module tb_register_bank_sb;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int AW  = 3;
  localparam logic [AW-1:0] PCA = 3'd7;
  localparam logic [DW-1:0] RPC = 16'h0000;

  logic           clk;
  logic           reset;
  logic [AW-1:0]  rd_addr1, rd_addr2;
  logic [DW-1:0]  rd_data1, rd_data2;
  logic           rd_busy1, rd_busy2;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           pc_wr_en;
  logic [DW-1:0]  pc_wr_data;
  logic [DW-1:0]  pc_out;
  logic           claim_en;
  logic [AW-1:0]  claim_addr;
  logic [NR*DW-1:0] all_regs;
  logic           burst_start;
  logic [NR-1:0]  burst_mask;
  logic           burst_ready;
  logic           burst_valid;
  logic [AW-1:0]  burst_addr;
  logic [DW-1:0]  burst_data;
  logic           burst_busy;
  logic           burst_done;

  register_bank_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_out(pc_out),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .all_regs(all_regs),
    .burst_start(burst_start), .burst_mask(burst_mask), .burst_ready(burst_ready),
    .burst_valid(burst_valid), .burst_addr(burst_addr), .burst_data(burst_data),
    .burst_busy(burst_busy), .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic [AW-1:0] beat_q [$];
  logic          m_done;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
`ifdef REGBANK_BYPASS_EN
    if (wr_en && wr_addr != PCA && wr_addr == a) return wr_data;
    if (pc_wr_en && a == PCA) return pc_wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGBANK_BYPASS_EN
    if (wr_en && wr_addr != PCA && wr_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NR*DW-1:0] exp_dump();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = (i == NR - 1) ? RPC : 16'h0000;
      m_busy[i] = 1'b0;
    end
    beat_q.delete();
    m_done = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    pc_wr_en = 1'b0; pc_wr_data = 16'h0000;
    claim_en = 1'b0; claim_addr = 3'd0;
    burst_start = 1'b0; burst_mask = 8'h00; burst_ready = 1'b0;
  endtask

  // Check all outputs against the model, then advance model across one edge.
  task automatic run_cycle();
    logic was_done;
    logic was_emit;
    #2;
    check_eq("rd_data1", rd_data1, exp_read(rd_addr1));
    check_eq("rd_data2", rd_data2, exp_read(rd_addr2));
    check_eq("rd_busy1", rd_busy1, exp_busy(rd_addr1));
    check_eq("rd_busy2", rd_busy2, exp_busy(rd_addr2));
    check_eq("pc_out", pc_out, m_regs[NR-1]);
    check_eq("all_regs", all_regs, exp_dump());
    check_eq("burst_valid", burst_valid, beat_q.size() > 0);
    check_eq("burst_busy", burst_busy, (beat_q.size() > 0) || m_done);
    check_eq("burst_done", burst_done, m_done);
    if (beat_q.size() > 0) begin
      check_eq("burst_addr", burst_addr, beat_q[0]);
      check_eq("burst_data", burst_data, exp_read(beat_q[0]));
    end
    @(posedge clk);
    if (wr_en && wr_addr != PCA) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (pc_wr_en) m_regs[NR-1] = pc_wr_data;
    if (claim_en && claim_addr != PCA) m_busy[claim_addr] = 1'b1;
    was_done = m_done;
    was_emit = beat_q.size() > 0;
    m_done = 1'b0;
    if (was_done) begin
      m_done = 1'b0;
    end else if (was_emit) begin
      if (burst_ready) begin
        void'(beat_q.pop_front());
        if (beat_q.size() == 0) m_done = 1'b1;
      end
    end else if (burst_start) begin
      for (int i = 0; i < NR; i++) if (burst_mask[i]) beat_q.push_back(3'(i));
      if (beat_q.size() == 0) m_done = 1'b1;
    end
    #1;
  endtask

  // Assert reset asynchronously, check its immediate effect, release after an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_valid", burst_valid, 1'b0);
    check_eq("rst_done", burst_done, 1'b0);
    check_eq("rst_busy", burst_busy, 1'b0);
    check_eq("rst_pc", pc_out, RPC);
    check_eq("rst_dump", all_regs, exp_dump());
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_baddr", burst_addr, 3'd0);
  endtask

  initial begin
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Read every address after reset.
    for (int i = 0; i < NR; i++) begin
      rd_addr1 = 3'(i); rd_addr2 = 3'(NR - 1 - i);
      run_cycle();
    end

    // General writes, dropped PC write, PC port.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    run_cycle();
    idle_inputs(); rd_addr1 = 3'd3;
    #1; check_eq("r3_write", rd_data1, 16'hBEEF);
    run_cycle();
    wr_en = 1'b1; wr_addr = PCA; wr_data = 16'h1234;
    run_cycle();
    idle_inputs();
    #1; check_eq("pc_drop", pc_out, RPC);
    pc_wr_en = 1'b1; pc_wr_data = 16'h0040;
    run_cycle();
    idle_inputs();
    #1; check_eq("pc_write", pc_out, 16'h0040);
    run_cycle();

    // Scoreboard.
    rd_addr2 = 3'd2;
    claim_en = 1'b1; claim_addr = 3'd2;
    run_cycle();
    idle_inputs();
    #1; check_eq("claim_busy", rd_busy2, 1'b1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555; claim_en = 1'b1; claim_addr = 3'd2;
    run_cycle();
    idle_inputs();
    #1; check_eq("claim_wins", rd_busy2, 1'b1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h6666;
    run_cycle();
    idle_inputs();
    #1; check_eq("write_clears", rd_busy2, 1'b0);
    claim_en = 1'b1; claim_addr = PCA; rd_addr2 = PCA;
    run_cycle();
    idle_inputs();
    #1; check_eq("pc_claim_ign", rd_busy2, 1'b0);
    run_cycle();

    // Burst 0xA5 with ready held, then with ready toggling.
    burst_start = 1'b1; burst_mask = 8'hA5; burst_ready = 1'b1;
    run_cycle();
    burst_start = 1'b0;
    for (int i = 0; i < 7; i++) run_cycle();
    burst_start = 1'b1; burst_mask = 8'hA5; burst_ready = 1'b0;
    run_cycle();
    burst_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      burst_ready = i[0];
      run_cycle();
    end

    // Full mask: eight beats back to back.
    burst_start = 1'b1; burst_mask = 8'hFF; burst_ready = 1'b1;
    run_cycle();
    burst_start = 1'b0;
    for (int i = 0; i < 10; i++) run_cycle();

    // Empty mask: done pulse only.
    burst_start = 1'b1; burst_mask = 8'h00;
    run_cycle();
    burst_start = 1'b0;
    #1; check_eq("mask0_done", burst_done, 1'b1);
    run_cycle();
    run_cycle();

    // Reset during the beat at address 5.
    burst_start = 1'b1; burst_mask = 8'hA5; burst_ready = 1'b1;
    run_cycle();
    burst_start = 1'b0;
    run_cycle();
    run_cycle();
    #1;
    check_eq("pre_rst_addr", burst_addr, 3'd5);
    check_eq("pre_rst_valid", burst_valid, 1'b1);
    do_reset();
    idle_inputs();
    for (int i = 0; i < 3; i++) run_cycle();

    // Same-cycle visibility of a write to R4.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0011;
    run_cycle();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00AA; rd_addr1 = 3'd4;
    #1;
`ifdef REGBANK_BYPASS_EN
    check_eq("r4_same_cycle", rd_data1, 16'h00AA);
`else
    check_eq("r4_same_cycle", rd_data1, 16'h0011);
`endif
    run_cycle();
    idle_inputs();
    #1; check_eq("r4_next_cycle", rd_data1, 16'h00AA);
    run_cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rd_addr1    = 3'($urandom_range(0, 7));
      rd_addr2    = 3'($urandom_range(0, 7));
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_addr     = 3'($urandom_range(0, 7));
      wr_data     = 16'($urandom);
      pc_wr_en    = ($urandom_range(0, 7) == 0);
      pc_wr_data  = 16'($urandom);
      claim_en    = ($urandom_range(0, 2) == 0);
      claim_addr  = 3'($urandom_range(0, 7));
      burst_start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       burst_mask = 8'h00;
        1:       burst_mask = 8'hFF;
        default: burst_mask = 8'($urandom);
      endcase
      burst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        run_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
